vc_crossbar3_ctrl_sd: RTL and testbench
=======================================

VC_CROSSBAR3_CTRL_SD -- requirements
Module: vc_Crossbar3Ctrl_sd

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset.
REQ-002 Parameter: p_lock_en, default 1, meaning 1 holds a grant until the last flit of a packet and 0 arbitrates every flit.
REQ-003 Port: clk  input  1  clock; all state updates on the rising edge.
REQ-004 Port: reset  input  1  synchronous active-high reset.
REQ-005 Port: domain  input  2  security domain of all traffic, label {L}, passed through unchanged to domain_out.
REQ-006 Port: in_val  input  3  per-input request valid, bit i = input i, label {L}.
REQ-007 Port: in_dest0, in_dest1, in_dest2  input  2 each  destination output, 0..2 legal and 3 illegal, label {L}.
REQ-008 Port: in_last  input  3  per-input last-flit-of-packet flag, label {L}.
REQ-009 Port: in_rdy  output  3  per-input ready, label {L}.
REQ-010 Port: out_rdy  input  3  per-output downstream ready, label {L}.
REQ-011 Port: out_val  output  3  per-output valid, label {L}.
REQ-012 Port: sel0, sel1, sel2  output  2 each  crossbar mux selects, value n selects input n, label {L}.
REQ-013 Port: domain_out  output  2  equals domain, label {L}.
REQ-014 Port: err  output  1  sticky flag for a consumed illegal-destination flit, label {L}.

Function
REQ-015 Each output k SHALL hold an FSM with states IDLE and BUSY, plus a 2-bit owner register and a 2-bit round-robin pointer ptr_k with range 0..2.
REQ-016 In IDLE, the candidates for output k SHALL be the inputs i with in_val[i]=1, dest_i=k, and i not the owner of any BUSY output.
REQ-017 In IDLE, the winner SHALL be the first candidate found scanning ptr_k, ptr_k+1, ptr_k+2 mod 3; the grant is combinational in the same cycle.
REQ-018 In BUSY, the winner SHALL be the owner, regardless of its dest field.
REQ-019 For each output k: out_val[k] = winner exists and in_val[winner]; sel_k = winner; with no winner, sel_k SHALL be 0.
REQ-020 For each input i granted to output k: in_rdy[i] = out_rdy[k]. An input with no grant SHALL see in_rdy[i]=0, except as stated in REQ-024.
REQ-021 A transfer on output k SHALL occur when out_val[k]=1 and out_rdy[k]=1 in the same cycle.
REQ-022 On a transfer, FSM next state:
- in_last=0 and p_lock_en=1: BUSY, owner = winner.
- otherwise: IDLE, and ptr_k = (winner+1) mod 3.
REQ-023 BUSY with the owner's in_val=0 SHALL keep BUSY, with out_val[k]=0.
REQ-024 An idle-eligible input (valid, not owner of any BUSY output) with dest=3 SHALL see in_rdy=1; the flit is consumed and dropped, and err is set the next cycle and held until reset.
REQ-025 Simultaneous contention: outputs SHALL arbitrate independently. An input is candidate for at most one output, since dest is single-valued and owners are excluded elsewhere.
REQ-026 The block SHALL have zero latency from request to grant and no internal data storage.
REQ-027 ptr_k SHALL change only on a packet-completing transfer.

Reset
REQ-028 While reset=1, all outputs SHALL be forced: out_val=0, in_rdy=0, sel0..2=0, err=0.
REQ-029 On reset: all FSMs go to IDLE, owners to 0, ptrs to 0.
REQ-030 Reset asserted mid-packet SHALL abandon the packet; there is no transfer in the reset cycle.
REQ-031 The cycle after reset deasserts SHALL arbitrate from ptr=0.

Verification
REQ-032 Contention: in_val=3'b111, all dest=1, in_last=1, out_rdy=3'b111 for 3 cycles -> sel1 = 0, then 1, then 2; out_val=3'b010 each cycle.
REQ-033 Packet lock: input 2 sends 3 flits to dest 0 with in_last=0,0,1 while input 0 requests dest 0 -> sel0=2 for all 3 transfers; input 0 granted in cycle 4; ptr0=0 after the lock releases.
REQ-034 Backpressure: single request from input 1 to dest 2 with out_rdy[2]=0 for 4 cycles, then 1 -> out_val[2]=1 throughout, in_rdy[1]=0 for 4 cycles then 1; exactly one transfer.
REQ-035 Parallel paths: in0 to 2, in1 to 0, in2 to 1, all ready -> out_val=3'b111, sel0=1, sel1=2, sel2=0, in_rdy=3'b111 in the same cycle.
REQ-036 Illegal destination: in_val[0]=1 with dest=3 -> in_rdy[0]=1 and out_val=0; err=1 the next cycle, staying 1 until reset.
REQ-037 Mid-packet reset: output 1 BUSY with owner 2, then reset for 1 cycle -> FSM returns to IDLE; a following request from input 0 to dest 1 is granted immediately.

Source files
------------

// File: rtl/vc_crossbar3_ctrl_sd.sv
// 3x3 virtual-channel crossbar controller: per-output round-robin arbitration with
// optional packet locking, combinational grant, sticky flag for illegal destinations.
module vc_crossbar3_ctrl_sd #(
  parameter bit p_lock_en = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] domain,
  input  logic [2:0] in_val,
  input  logic [1:0] in_dest0,
  input  logic [1:0] in_dest1,
  input  logic [1:0] in_dest2,
  input  logic [2:0] in_last,
  output logic [2:0] in_rdy,
  input  logic [2:0] out_rdy,
  output logic [2:0] out_val,
  output logic [1:0] sel0,
  output logic [1:0] sel1,
  output logic [1:0] sel2,
  output logic [1:0] domain_out,
  output logic       err,
  output logic [2:0] dbg_busy,
  output logic [5:0] dbg_ptr
);

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  state_t     state_q [3];
  state_t     state_d [3];
  logic [1:0] owner_q [3];
  logic [1:0] owner_d [3];
  logic [1:0] ptr_q   [3];
  logic [1:0] ptr_d   [3];
  logic       err_q;

  logic [1:0] dest [3];
  logic [1:0] win  [3];
  logic [2:0] has;
  logic [2:0] owned;
  logic [2:0] drop;
  logic [2:0] xfer;
  logic [2:0] val_c;
  logic [2:0] rdy_c;

  function automatic logic [1:0] inc3(input logic [1:0] x);
    return (x == 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  assign dest[0] = in_dest0;
  assign dest[1] = in_dest1;
  assign dest[2] = in_dest2;

  // An input that owns a locked output may not compete anywhere else.
  always_comb begin
    owned = '0;
    for (int k = 0; k < 3; k++) begin
      for (int i = 0; i < 3; i++) begin
        if (state_q[k] == BUSY && owner_q[k] == i[1:0]) owned[i] = 1'b1;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      logic [1:0] cand;
      win[k] = 2'd0;
      has[k] = 1'b0;
      cand   = ptr_q[k];
      if (state_q[k] == BUSY) begin
        win[k] = owner_q[k];
        has[k] = 1'b1;
      end else begin
        for (int j = 0; j < 3; j++) begin
          if (!has[k] && in_val[cand] && dest[cand] == k[1:0] && !owned[cand]) begin
            win[k] = cand;
            has[k] = 1'b1;
          end
          cand = inc3(cand);
        end
      end
    end
  end

  // Illegal-destination flits are accepted and discarded so they cannot block the input.
  always_comb begin
    rdy_c = '0;
    for (int k = 0; k < 3; k++) begin
      val_c[k] = has[k] && in_val[win[k]];
      xfer[k]  = val_c[k] && out_rdy[k];
      for (int i = 0; i < 3; i++) begin
        if (has[k] && win[k] == i[1:0]) rdy_c[i] = out_rdy[k];
      end
    end
    for (int i = 0; i < 3; i++) begin
      drop[i] = in_val[i] && dest[i] == 2'd3 && !owned[i];
      if (drop[i]) rdy_c[i] = 1'b1;
    end
  end

  always_comb begin
    for (int k = 0; k < 3; k++) begin
      state_d[k] = state_q[k];
      owner_d[k] = owner_q[k];
      ptr_d[k]   = ptr_q[k];
      if (xfer[k]) begin
        if (p_lock_en && !in_last[win[k]]) begin
          state_d[k] = BUSY;
          owner_d[k] = win[k];
        end else begin
          state_d[k] = IDLE;
          ptr_d[k]   = inc3(win[k]);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 0; k < 3; k++) begin
        state_q[k] <= IDLE;
        owner_q[k] <= 2'd0;
        ptr_q[k]   <= 2'd0;
      end
      err_q <= 1'b0;
    end else begin
      for (int k = 0; k < 3; k++) begin
        state_q[k] <= state_d[k];
        owner_q[k] <= owner_d[k];
        ptr_q[k]   <= ptr_d[k];
      end
      err_q <= err_q | (|drop);
    end
  end

  assign out_val    = reset ? 3'b000 : val_c;
  assign in_rdy     = reset ? 3'b000 : rdy_c;
  assign sel0       = reset ? 2'd0 : win[0];
  assign sel1       = reset ? 2'd0 : win[1];
  assign sel2       = reset ? 2'd0 : win[2];
  assign err        = err_q & ~reset;
  assign domain_out = domain;
  assign dbg_busy   = {state_q[2] == BUSY, state_q[1] == BUSY, state_q[0] == BUSY};
  assign dbg_ptr    = {ptr_q[2], ptr_q[1], ptr_q[0]};

endmodule

// File: tb/tb_vc_crossbar3_ctrl_sd.sv
// Bench for vc_crossbar3_ctrl_sd: directed scenarios with literal expectations plus
// random traffic compared every cycle against a distance-based arbitration model.
module tb_vc_crossbar3_ctrl_sd;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] domain;
  logic [2:0] in_val;
  logic [1:0] in_dest0, in_dest1, in_dest2;
  logic [2:0] in_last;
  logic [2:0] in_rdy;
  logic [2:0] out_rdy;
  logic [2:0] out_val;
  logic [1:0] sel0, sel1, sel2;
  logic [1:0] domain_out;
  logic       err;
  logic [2:0] dbg_busy;
  logic [5:0] dbg_ptr;

  int errors = 0;
  int checks = 0;
  bit started = 0;
  logic [1:0] exp_q[$];

  // clock / reset
  always #5 clk = ~clk;

  vc_crossbar3_ctrl_sd #(.p_lock_en(1'b1)) dut (
    .clk(clk), .reset(reset), .domain(domain), .in_val(in_val),
    .in_dest0(in_dest0), .in_dest1(in_dest1), .in_dest2(in_dest2),
    .in_last(in_last), .in_rdy(in_rdy), .out_rdy(out_rdy), .out_val(out_val),
    .sel0(sel0), .sel1(sel1), .sel2(sel2), .domain_out(domain_out), .err(err),
    .dbg_busy(dbg_busy), .dbg_ptr(dbg_ptr)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: state advanced at posedge from values computed at negedge
  bit m_busy [3];
  int m_owner[3];
  int m_ptr  [3];
  bit m_err;
  bit n_busy [3];
  int n_owner[3];
  int n_ptr  [3];
  bit n_err;

  function automatic int dest_of(input int i);
    case (i)
      0: return int'(in_dest0);
      1: return int'(in_dest1);
      default: return int'(in_dest2);
    endcase
  endfunction

  always @(negedge clk) begin
    if (started) begin
      bit owned[3];
      int w[3];
      bit e_val[3];
      bit e_rdy[3];
      int e_sel[3];
      logic [2:0] ev, er;
      for (int i = 0; i < 3; i++) begin
        owned[i] = 0;
        e_rdy[i] = 0;
        for (int k = 0; k < 3; k++) if (m_busy[k] && m_owner[k] == i) owned[i] = 1;
      end
      for (int k = 0; k < 3; k++) begin
        if (m_busy[k]) w[k] = m_owner[k];
        else begin
          int bd;
          bd = 99;
          w[k] = -1;
          for (int i = 0; i < 3; i++) begin
            if (in_val[i] && dest_of(i) == k && !owned[i] && (i - m_ptr[k] + 3) % 3 < bd) begin
              bd = (i - m_ptr[k] + 3) % 3;
              w[k] = i;
            end
          end
        end
        e_val[k] = (w[k] >= 0) && in_val[w[k]];
        e_sel[k] = (w[k] >= 0) ? w[k] : 0;
      end
      for (int k = 0; k < 3; k++) if (w[k] >= 0) e_rdy[w[k]] = out_rdy[k];
      n_err = m_err;
      for (int i = 0; i < 3; i++)
        if (in_val[i] && dest_of(i) == 3 && !owned[i]) begin
          e_rdy[i] = 1;
          n_err = 1;
        end
      for (int k = 0; k < 3; k++) begin
        n_busy[k] = m_busy[k]; n_owner[k] = m_owner[k]; n_ptr[k] = m_ptr[k];
        if (e_val[k] && out_rdy[k]) begin
          if (!in_last[w[k]]) begin n_busy[k] = 1; n_owner[k] = w[k]; end
          else begin n_busy[k] = 0; n_ptr[k] = (w[k] + 1) % 3; end
        end
      end
      ev = {e_val[2], e_val[1], e_val[0]};
      er = {e_rdy[2], e_rdy[1], e_rdy[0]};
      if (reset) begin
        ev = 0; er = 0; e_sel = '{0, 0, 0};
        n_err = 0;
        for (int k = 0; k < 3; k++) begin n_busy[k] = 0; n_owner[k] = 0; n_ptr[k] = 0; end
      end
      exp_q.push_back(2'(e_sel[0]));
      exp_q.push_back(2'(e_sel[1]));
      exp_q.push_back(2'(e_sel[2]));
      chk("m_out_val", out_val, ev);
      chk("m_in_rdy", in_rdy, er);
      chk("m_sel0", sel0, exp_q.pop_front());
      chk("m_sel1", sel1, exp_q.pop_front());
      chk("m_sel2", sel2, exp_q.pop_front());
      chk("m_err", err, reset ? 0 : m_err);
      chk("m_domain", domain_out, domain);
      chk("m_ptr", dbg_ptr, {2'(m_ptr[2]), 2'(m_ptr[1]), 2'(m_ptr[0])});
    end
  end

  always @(posedge clk) begin
    if (started) begin
      m_busy = n_busy; m_owner = n_owner; m_ptr = n_ptr; m_err = n_err;
    end
  end

  // driver: apply one cycle of inputs just after the rising edge, return after falling edge
  task automatic cyc(input logic [2:0] v, input logic [1:0] d0, input logic [1:0] d1,
                     input logic [1:0] d2, input logic [2:0] l, input logic [2:0] r,
                     input logic rst);
    @(posedge clk);
    #1;
    in_val = v; in_dest0 = d0; in_dest1 = d1; in_dest2 = d2;
    in_last = l; out_rdy = r; reset = rst;
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc(3'b000, 0, 0, 0, 3'b000, 3'b000, 1'b1);
  endtask

  int nxfer;

  initial begin
    reset = 1; domain = 2'd2; in_val = 0; in_dest0 = 0; in_dest1 = 0; in_dest2 = 0;
    in_last = 0; out_rdy = 0;
    for (int k = 0; k < 3; k++) begin m_busy[k] = 0; m_owner[k] = 0; m_ptr[k] = 0; end
    m_err = 0;
    @(posedge clk);
    started = 1;

    // reset forces all outputs low even with requests present
    cyc(3'b111, 1, 1, 1, 3'b111, 3'b111, 1'b1);
    chk("rst_out_val", out_val, 0);
    chk("rst_in_rdy", in_rdy, 0);
    chk("rst_sel1", sel1, 0);
    chk("rst_err", err, 0);

    // contention: round robin on output 1
    do_reset();
    cyc(3'b111, 1, 1, 1, 3'b111, 3'b111, 1'b0);
    chk("rr_sel1_a", sel1, 0); chk("rr_val_a", out_val, 3'b010); chk("rr_rdy_a", in_rdy, 3'b001);
    cyc(3'b111, 1, 1, 1, 3'b111, 3'b111, 1'b0);
    chk("rr_sel1_b", sel1, 1); chk("rr_val_b", out_val, 3'b010);
    cyc(3'b111, 1, 1, 1, 3'b111, 3'b111, 1'b0);
    chk("rr_sel1_c", sel1, 2); chk("rr_val_c", out_val, 3'b010);

    // packet lock: input 2 holds output 0 for three flits
    do_reset();
    cyc(3'b100, 0, 0, 0, 3'b000, 3'b111, 1'b0);
    chk("lk_sel0_1", sel0, 2);
    cyc(3'b101, 0, 0, 0, 3'b000, 3'b111, 1'b0);
    chk("lk_sel0_2", sel0, 2); chk("lk_rdy_2", in_rdy, 3'b100); chk("lk_busy", dbg_busy, 3'b001);
    cyc(3'b101, 0, 0, 0, 3'b100, 3'b111, 1'b0);
    chk("lk_sel0_3", sel0, 2);
    cyc(3'b001, 0, 0, 0, 3'b001, 3'b111, 1'b0);
    chk("lk_sel0_4", sel0, 0); chk("lk_val_4", out_val, 3'b001); chk("lk_ptr0", dbg_ptr[1:0], 0);

    // backpressure: one transfer only once out_rdy[2] rises
    do_reset();
    nxfer = 0;
    for (int c = 0; c < 5; c++) begin
      cyc(3'b010, 0, 2, 0, 3'b111, (c < 4) ? 3'b011 : 3'b111, 1'b0);
      chk("bp_val", out_val, 3'b100);
      chk("bp_rdy", in_rdy, (c < 4) ? 3'b000 : 3'b010);
      if (out_val[2] && out_rdy[2]) nxfer++;
    end
    cyc(3'b000, 0, 0, 0, 3'b111, 3'b111, 1'b0);
    chk("bp_nxfer", nxfer, 1);

    // parallel paths
    do_reset();
    cyc(3'b111, 2, 0, 1, 3'b111, 3'b111, 1'b0);
    chk("pp_val", out_val, 3'b111); chk("pp_rdy", in_rdy, 3'b111);
    chk("pp_sel0", sel0, 1); chk("pp_sel1", sel1, 2); chk("pp_sel2", sel2, 0);

    // illegal destination: dropped, err sticky until reset
    do_reset();
    cyc(3'b001, 3, 0, 0, 3'b111, 3'b111, 1'b0);
    chk("il_rdy", in_rdy, 3'b001); chk("il_val", out_val, 0); chk("il_err0", err, 0);
    cyc(3'b000, 0, 0, 0, 3'b111, 3'b111, 1'b0);
    chk("il_err1", err, 1);
    cyc(3'b000, 0, 0, 0, 3'b111, 3'b111, 1'b0);
    chk("il_err2", err, 1);
    do_reset();
    cyc(3'b000, 0, 0, 0, 3'b111, 3'b111, 1'b0);
    chk("il_err_clr", err, 0);

    // mid-packet reset releases the lock
    do_reset();
    cyc(3'b100, 0, 0, 1, 3'b000, 3'b111, 1'b0);
    cyc(3'b100, 0, 0, 1, 3'b000, 3'b111, 1'b0);
    chk("mr_busy", dbg_busy, 3'b010);
    cyc(3'b100, 0, 0, 1, 3'b000, 3'b111, 1'b1);
    cyc(3'b001, 1, 0, 0, 3'b111, 3'b111, 1'b0);
    chk("mr_busy_clr", dbg_busy, 3'b000);
    chk("mr_sel1", sel1, 0); chk("mr_val", out_val, 3'b010); chk("mr_rdy", in_rdy, 3'b001);

    // random traffic against the model
    for (int c = 0; c < 2000; c++) begin
      logic [1:0] d[3];
      for (int i = 0; i < 3; i++) begin
        int r;
        r = $urandom_range(0, 11);
        d[i] = (r == 11) ? 2'd3 : 2'(r % 3);
      end
      domain = 2'($urandom_range(0, 3));
      cyc(3'($urandom_range(0, 7)), d[0], d[1], d[2], 3'($urandom_range(0, 7)),
          3'($urandom_range(0, 7)) | 3'($urandom_range(0, 7)), $urandom_range(0, 99) == 0);
    end

    @(posedge clk);
    started = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
